// File: rtl/food_spawner.sv
// Food placement FSM: samples random grid cells and asks the snake body whether each one is free.
// Define SPAWN_SCAN_EN to add a raster-scan fallback; without it, exhausting the tries pulses fail.
module food_spawner #(
  parameter int GRID_W    = 32,
  parameter int GRID_H    = 24,
  parameter int COORD_W   = 6,
  parameter int MAX_TRIES = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [15:0]        rnd,
  input  logic               spawn_req,
  output logic               busy,
  output logic               chk_valid,
  output logic [COORD_W-1:0] chk_x,
  output logic [COORD_W-1:0] chk_y,
  input  logic               chk_ready,
  input  logic               chk_occupied,
  output logic               food_valid,
  output logic [COORD_W-1:0] food_x,
  output logic [COORD_W-1:0] food_y,
  output logic               fail
);

`ifdef SPAWN_SCAN_EN
  typedef enum logic [2:0] {IDLE, SAMPLE, QUERY, SCAN, SCANQ} state_t;
  localparam logic [COORD_W-1:0]   XMAX     = COORD_W'(GRID_W - 1);
  localparam logic [2*COORD_W-1:0] CNT_LAST = (2*COORD_W)'(GRID_W * GRID_H - 1);
`else
  typedef enum logic [1:0] {IDLE, SAMPLE, QUERY} state_t;
`endif

  localparam logic [COORD_W:0] GW   = (COORD_W+1)'(GRID_W);
  localparam logic [COORD_W:0] GH   = (COORD_W+1)'(GRID_H);
  localparam logic [3:0]       TMAX = 4'(MAX_TRIES);

  state_t             state_q, state_d;
  logic [3:0]         tries_q, tries_d, tries_inc;
  logic [COORD_W-1:0] chk_x_q, chk_x_d, chk_y_q, chk_y_d;
  logic [COORD_W-1:0] food_x_q, food_x_d, food_y_q, food_y_d;
  logic               food_valid_q, food_valid_d;
  logic               fail_q, fail_d;
  logic               fallback;
`ifdef SPAWN_SCAN_EN
  logic [2*COORD_W-1:0] scan_cnt_q, scan_cnt_d;
`endif

  logic [COORD_W-1:0] cand_x, cand_y;
  logic               cand_ok;
  logic               unused_rnd;

  assign cand_x     = rnd[COORD_W-1:0];
  assign cand_y     = rnd[8+COORD_W-1:8];
  assign cand_ok    = ({1'b0, cand_x} < GW) && ({1'b0, cand_y} < GH);
  assign tries_inc  = (tries_q == 4'hF) ? 4'hF : tries_q + 4'd1;
  assign unused_rnd = ^rnd;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      tries_q      <= '0;
      chk_x_q      <= '0;
      chk_y_q      <= '0;
      food_x_q     <= '0;
      food_y_q     <= '0;
      food_valid_q <= 1'b0;
      fail_q       <= 1'b0;
`ifdef SPAWN_SCAN_EN
      scan_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      tries_q      <= tries_d;
      chk_x_q      <= chk_x_d;
      chk_y_q      <= chk_y_d;
      food_x_q     <= food_x_d;
      food_y_q     <= food_y_d;
      food_valid_q <= food_valid_d;
      fail_q       <= fail_d;
`ifdef SPAWN_SCAN_EN
      scan_cnt_q   <= scan_cnt_d;
`endif
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d      = state_q;
    tries_d      = tries_q;
    chk_x_d      = chk_x_q;
    chk_y_d      = chk_y_q;
    food_x_d     = food_x_q;
    food_y_d     = food_y_q;
    food_valid_d = food_valid_q;
    fail_d       = 1'b0;
    fallback     = 1'b0;
`ifdef SPAWN_SCAN_EN
    scan_cnt_d   = scan_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (spawn_req) begin
          food_valid_d = 1'b0;
          tries_d      = '0;
          state_d      = SAMPLE;
        end
      end
      SAMPLE: begin
        if (cand_ok) begin
          chk_x_d = cand_x;
          chk_y_d = cand_y;
          state_d = QUERY;
        end else begin
          tries_d = tries_inc;
          if (tries_inc >= TMAX) fallback = 1'b1;
        end
      end
      QUERY: begin
        if (chk_ready) begin
          if (!chk_occupied) begin
            food_x_d     = chk_x_q;
            food_y_d     = chk_y_q;
            food_valid_d = 1'b1;
            state_d      = IDLE;
          end else begin
            tries_d = tries_inc;
            if (tries_inc >= TMAX) fallback = 1'b1;
            else                   state_d  = SAMPLE;
          end
        end
      end
`ifdef SPAWN_SCAN_EN
      SCAN: state_d = SCANQ;
      SCANQ: begin
        if (chk_ready) begin
          if (!chk_occupied) begin
            food_x_d     = chk_x_q;
            food_y_d     = chk_y_q;
            food_valid_d = 1'b1;
            state_d      = IDLE;
          end else if (scan_cnt_q == CNT_LAST) begin
            fail_d  = 1'b1;
            state_d = IDLE;
          end else begin
            scan_cnt_d = scan_cnt_q + 1'b1;
            state_d    = SCAN;
            if (chk_x_q == XMAX) begin
              chk_x_d = '0;
              chk_y_d = chk_y_q + 1'b1;
            end else begin
              chk_x_d = chk_x_q + 1'b1;
            end
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    if (fallback) begin
`ifdef SPAWN_SCAN_EN
      state_d    = SCAN;
      scan_cnt_d = '0;
      chk_x_d    = '0;
      chk_y_d    = '0;
`else
      fail_d  = 1'b1;
      state_d = IDLE;
`endif
    end
  end

  // Outputs
  always_comb begin
    busy      = (state_q != IDLE);
`ifdef SPAWN_SCAN_EN
    chk_valid = (state_q == QUERY) || (state_q == SCANQ);
`else
    chk_valid = (state_q == QUERY);
`endif
    chk_x      = chk_x_q;
    chk_y      = chk_y_q;
    food_valid = food_valid_q;
    food_x     = food_x_q;
    food_y     = food_y_q;
    fail       = fail_q;
  end

endmodule

// File: tb/tb_food_spawner.sv
// Directed bench for food_spawner: latency, rejection, exhaustion/scan fallback, stall and reset.
module tb_food_spawner;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [15:0]   rnd = 16'h0;
  logic          spawn_req = 1'b0;
  logic          chk_ready = 1'b1;
  logic          chk_occupied;
  logic          busy, chk_valid, food_valid, fail;
  logic [CW-1:0] chk_x, chk_y, food_x, food_y;

  int checks = 0;
  int failures = 0;
  int occ_mode = 0;  // 0: all free, 1: all occupied, 2: only (1,1) free

  food_spawner dut (
    .clk(clk), .rst_n(rst_n), .rnd(rnd), .spawn_req(spawn_req),
    .busy(busy), .chk_valid(chk_valid), .chk_x(chk_x), .chk_y(chk_y),
    .chk_ready(chk_ready), .chk_occupied(chk_occupied),
    .food_valid(food_valid), .food_x(food_x), .food_y(food_y), .fail(fail)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (occ_mode)
      0:       chk_occupied = 1'b0;
      1:       chk_occupied = 1'b1;
      default: chk_occupied = !(chk_x == 6'd1 && chk_y == 6'd1);
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if ({busy, chk_valid, food_valid, fail} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=0000", {busy, chk_valid, food_valid, fail});
    end
    checks++;
    if ({chk_x, chk_y, food_x, food_y} !== '0) begin
      failures++;
      $display("FAIL reset_coords got=%h want=0", {chk_x, chk_y, food_x, food_y});
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset busy got=%b want=0", busy);
    end
    $display("tb: test_reset done");
  endtask

  task automatic test_single_free();
    logic [CW-1:0] fx, fy;
    occ_mode  = 0;
    chk_ready = 1'b1;
    rnd       = 16'h0305;
    spawn_req = 1'b1;
    step();
    spawn_req = 1'b0;
    checks++;
    if ({busy, chk_valid, food_valid} !== 3'b100) begin
      failures++;
      $display("FAIL lat_c1 busy/chk_valid/food_valid got=%b want=100", {busy, chk_valid, food_valid});
    end
    step();
    checks++;
    if ({chk_valid, food_valid, chk_x, chk_y} !== {1'b1, 1'b0, 6'd5, 6'd3}) begin
      failures++;
      $display("FAIL lat_c2 chk_valid=%b food_valid=%b chk=(%0d,%0d) want 1 0 (5,3)",
               chk_valid, food_valid, chk_x, chk_y);
    end
    step();
    checks++;
    if ({food_valid, chk_valid, busy, food_x, food_y} !== {3'b100, 6'd5, 6'd3}) begin
      failures++;
      $display("FAIL lat_c3 food_valid=%b chk_valid=%b busy=%b food=(%0d,%0d) want 1 0 0 (5,3)",
               food_valid, chk_valid, busy, food_x, food_y);
    end
    fx = food_x;
    fy = food_y;
    for (int i = 0; i < 3; i++) begin
      rnd = 16'($urandom);
      step();
      checks++;
      if ({food_valid, food_x, food_y} !== {1'b1, fx, fy}) begin
        failures++;
        $display("FAIL food_hold cyc=%0d got %b (%0d,%0d) want 1 (5,3)", i, food_valid, food_x, food_y);
      end
    end
    $display("tb: test_single_free done food=(%0d,%0d)", food_x, food_y);
  endtask

  task automatic test_reject();
    occ_mode  = 0;
    chk_ready = 1'b1;
    rnd       = 16'h3F3F;
    spawn_req = 1'b1;
    step();
    spawn_req = 1'b0;
    checks++;
    if ({food_valid, busy} !== 2'b01) begin
      failures++;
      $display("FAIL rej_clear food_valid/busy got=%b want=01", {food_valid, busy});
    end
    step();
    checks++;
    if ({chk_valid, busy} !== 2'b01) begin
      failures++;
      $display("FAIL rej_1 chk_valid/busy got=%b want=01", {chk_valid, busy});
    end
    step();
    checks++;
    if ({chk_valid, busy} !== 2'b01) begin
      failures++;
      $display("FAIL rej_2 chk_valid/busy got=%b want=01", {chk_valid, busy});
    end
    rnd = 16'h0102;
    step();
    checks++;
    if ({chk_valid, chk_x, chk_y} !== {1'b1, 6'd2, 6'd1}) begin
      failures++;
      $display("FAIL rej_query got %b (%0d,%0d) want 1 (2,1)", chk_valid, chk_x, chk_y);
    end
    step();
    checks++;
    if ({food_valid, food_x, food_y} !== {1'b1, 6'd2, 6'd1}) begin
      failures++;
      $display("FAIL rej_food got %b (%0d,%0d) want 1 (2,1)", food_valid, food_x, food_y);
    end
    $display("tb: test_reject done food=(%0d,%0d)", food_x, food_y);
  endtask

`ifndef SPAWN_SCAN_EN
  task automatic test_exhaust();
    int nq = 0, nf = 0, nfv = 0;
    occ_mode  = 1;
    chk_ready = 1'b1;
    rnd       = 16'h0305;
    spawn_req = 1'b1;
    step();
    spawn_req = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (chk_valid) nq++;
      if (fail) nf++;
      if (food_valid) nfv++;
      step();
    end
    checks++;
    if (nq !== 15) begin
      failures++;
      $display("FAIL exhaust_queries got=%0d want=15", nq);
    end
    checks++;
    if (nf !== 1) begin
      failures++;
      $display("FAIL exhaust_fail_cycles got=%0d want=1", nf);
    end
    checks++;
    if (nfv !== 0 || food_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL exhaust_end food_valid_cycles=%0d food_valid=%b busy=%b want 0 0 0", nfv, food_valid, busy);
    end
    $display("tb: test_exhaust done queries=%0d fail_cycles=%0d", nq, nf);
  endtask
`else
  task automatic test_scan();
    logic [CW-1:0] qx[$], qy[$];
    logic [CW-1:0] ex, ey;
    int nf = 0;
    bit done = 0;
    occ_mode  = 2;
    chk_ready = 1'b1;
    rnd       = 16'h0305;
    spawn_req = 1'b1;
    step();
    spawn_req = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (chk_valid) begin
        qx.push_back(chk_x);
        qy.push_back(chk_y);
      end
      if (fail) nf++;
      if (food_valid) done = 1;
      if (!done) step();
    end
    checks++;
    if (qx.size() != 49) begin
      failures++;
      $display("FAIL scan_count got=%0d want=49", qx.size());
    end
    for (int i = 0; i < 49 && i < qx.size(); i++) begin
      if (i < 15)      begin ex = 6'd5;       ey = 6'd3; end
      else if (i < 47) begin ex = 6'(i - 15); ey = 6'd0; end
      else             begin ex = 6'(i - 47); ey = 6'd1; end
      checks++;
      if (qx[i] !== ex || qy[i] !== ey) begin
        failures++;
        $display("FAIL scan_query idx=%0d got=(%0d,%0d) want=(%0d,%0d)", i, qx[i], qy[i], ex, ey);
      end
    end
    checks++;
    if ({done, food_x, food_y} !== {1'b1, 6'd1, 6'd1} || nf !== 0) begin
      failures++;
      $display("FAIL scan_food got %b (%0d,%0d) fails=%0d want 1 (1,1) 0", done, food_x, food_y, nf);
    end
    $display("tb: test_scan done queries=%0d", qx.size());
  endtask
`endif

  task automatic test_stall_reset();
    occ_mode  = 0;
    chk_ready = 1'b0;
    rnd       = 16'h0A07;
    spawn_req = 1'b1;
    step();
    spawn_req = 1'b0;
    step();
    checks++;
    if ({chk_valid, chk_x, chk_y} !== {1'b1, 6'd7, 6'd10}) begin
      failures++;
      $display("FAIL stall_query got %b (%0d,%0d) want 1 (7,10)", chk_valid, chk_x, chk_y);
    end
    for (int i = 0; i < 5; i++) begin
      rnd = 16'($urandom);
      step();
      checks++;
      if ({chk_valid, chk_x, chk_y, food_valid} !== {1'b1, 6'd7, 6'd10, 1'b0}) begin
        failures++;
        $display("FAIL stall_hold cyc=%0d got %b (%0d,%0d) fv=%b want 1 (7,10) 0",
                 i, chk_valid, chk_x, chk_y, food_valid);
      end
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, chk_valid, food_valid, fail, chk_x, chk_y, food_x, food_y} !== '0) begin
      failures++;
      $display("FAIL async_reset got busy=%b cv=%b fv=%b fail=%b chk=(%0d,%0d) food=(%0d,%0d) want all 0",
               busy, chk_valid, food_valid, fail, chk_x, chk_y, food_x, food_y);
    end
    chk_ready = 1'b1;
    step();
    step();
    rst_n     = 1'b1;
    rnd       = 16'h0305;
    spawn_req = 1'b1;
    step();
    spawn_req = 1'b0;
    checks++;
    if ({busy, fail, food_valid} !== 3'b100) begin
      failures++;
      $display("FAIL post_reset_accept busy/fail/fv got=%b want=100", {busy, fail, food_valid});
    end
    step();
    step();
    checks++;
    if ({food_valid, food_x, food_y} !== {1'b1, 6'd5, 6'd3}) begin
      failures++;
      $display("FAIL post_reset_food got %b (%0d,%0d) want 1 (5,3)", food_valid, food_x, food_y);
    end
    $display("tb: test_stall_reset done");
  endtask

  initial begin
    #1;
    test_reset();
    test_single_free();
    test_reject();
`ifndef SPAWN_SCAN_EN
    test_exhaust();
`else
    test_scan();
`endif
    test_stall_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/food_spawner.md
FOOD_SPAWNER -- requirements
Module: food_spawner

Interface
REQ-001 SHALL have parameter GRID_W, default 32, grid columns, range 2..2^COORD_W.
REQ-002 SHALL have parameter GRID_H, default 24, grid rows, range 2..2^COORD_W.
REQ-003 SHALL have parameter COORD_W, default 6, coordinate width, range 1..8.
REQ-004 SHALL have parameter MAX_TRIES, default 15, random attempts before fallback, range 1..15.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-007 SHALL have port rnd, input, 16 bits, free-running pseudo-random word from the 16-bit LFSR, new value each cycle.
REQ-008 SHALL have port spawn_req, input, 1 bit, request a new food cell.
REQ-009 SHALL have port busy, output, 1 bit, high when the FSM is not in IDLE.
REQ-010 SHALL have port chk_valid, output, 1 bit, occupancy query valid.
REQ-011 SHALL have ports chk_x and chk_y, outputs, COORD_W bits each, the queried cell.
REQ-012 SHALL have port chk_ready, input, 1 bit, the snake body answers in this cycle.
REQ-013 SHALL have port chk_occupied, input, 1 bit, cell is occupied; sampled only when chk_valid and chk_ready are both high.
REQ-014 SHALL have ports food_valid (1 bit), food_x and food_y (COORD_W bits each), outputs, the committed food cell.
REQ-015 SHALL have port fail, output, 1 bit, one-cycle pulse when no free cell is found.

Function
REQ-016 FSM states SHALL be IDLE, SAMPLE, QUERY, SCAN and SCANQ.
REQ-017 IDLE: spawn_req=1 SHALL clear food_valid, zero the try counter and move to SAMPLE; spawn_req outside IDLE SHALL be ignored.
REQ-018 SAMPLE: candidate SHALL be x=rnd[COORD_W-1:0] and y=rnd[8+COORD_W-1:8]; if x<GRID_W and y<GRID_H, latch it into chk_x/chk_y and go to QUERY.
REQ-019 SAMPLE out-of-range SHALL increment tries; the FSM stays in SAMPLE and uses the next rnd value, or takes the fallback (REQ-022) when tries reaches MAX_TRIES.
REQ-020 QUERY: chk_valid SHALL be 1, and chk_x/chk_y SHALL be held stable until the handshake completes (chk_valid and chk_ready both high).
REQ-021 On a QUERY handshake: free SHALL load food_x/food_y, set food_valid the next cycle and return to IDLE; occupied SHALL increment tries and return to SAMPLE, or take the fallback at MAX_TRIES.
REQ-022 Fallback SHALL be SCAN if SPAWN_SCAN_EN is defined, else assert fail for one cycle and return to IDLE with food_valid=0.
REQ-023 SCAN SHALL start at (0,0) and query cells in raster order through SCANQ with the same handshake as QUERY.
REQ-024 SCAN stepping: x wraps from GRID_W-1 to 0 with y+1.
REQ-025 The first free cell found in SCAN SHALL be committed as in REQ-021.
REQ-026 After GRID_W*GRID_H occupied answers, SCAN SHALL pulse fail, leave food_valid=0 and return to IDLE.
REQ-027 Latency: a free first in-range sample with chk_ready=1 SHALL give food_valid 3 cycles after the spawn_req cycle.
REQ-028 food_valid SHALL stay high with constant food_x/food_y until the next accepted spawn_req.
REQ-029 The try counter SHALL be 4 bits and SHALL saturate; the scan counter SHALL be 2*COORD_W bits.

Reset
REQ-030 Asserting rst_n=0 SHALL immediately force the IDLE state and zero the try and scan counters.
REQ-031 Asserting rst_n=0 SHALL immediately drive busy, chk_valid, chk_x, chk_y, food_valid, food_x, food_y and fail to 0.
REQ-032 Reset mid-query SHALL abandon the query with no commit and no fail pulse.
REQ-033 spawn_req SHALL be accepted in the first cycle after rst_n deasserts.

Configuration
REQ-034 Macro SPAWN_SCAN_EN defined: the SCAN/SCANQ states and the scan counter SHALL be compiled in; undefined: these SHALL be absent and the fallback is an immediate fail pulse.

Verification
REQ-035 rnd=16'h0305, chk_ready=1, chk_occupied=0, spawn_req pulse -> food (5,3) with food_valid high 3 cycles later, and chk_valid high exactly 1 cycle.
REQ-036 rnd=16'h3F3F for 2 cycles, then 16'h0102 -> 2 rejects, query (2,1), food (2,1).
REQ-037 Every query answered occupied, MAX_TRIES=15, macro undefined -> 15 attempts, then a fail pulse and food_valid=0.
REQ-038 Macro defined, all cells occupied except (1,1), all random candidates occupied -> scan queries (0,0), (1,0) ... (31,0), (0,1), (1,1), then food (1,1).
REQ-039 chk_ready held 0 for 5 cycles in QUERY -> chk_x/chk_y stable; rst_n pulsed low -> all outputs 0 and state IDLE.
